uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm_pkg.sv | 32 +++
 rtl/edge_bit_counter.sv | 41 ++++
 rtl/uart_rx_fsm.sv | 116 +++++++++++
 tb/tb_uart_rx_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fsm_pkg.sv
// Shared definitions for the UART receive controller: Gray-coded state codes,
// legal oversampling ratios and the offset of the check-enable edge.
package uart_rx_fsm_pkg;

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_START   = 3'b001;
  localparam logic [2:0] S_DATA    = 3'b011;
  localparam logic [2:0] S_PARITY  = 3'b010;
  localparam logic [2:0] S_STOP    = 3'b110;
  localparam logic [2:0] S_ERR_CHK = 3'b111;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic [5:0] CHK_OFFSET = 6'd2;

  // Any ratio other than 8/16/32 falls back to 8.
  function automatic logic [5:0] legalize_prescale(input logic [5:0] p);
    if (p == PRESCALE_16 || p == PRESCALE_32) return p;
    return PRESCALE_8;
  endfunction

  function automatic logic [5:0] chk_edge(input logic [5:0] p);
    return (p >> 1) + CHK_OFFSET;
  endfunction

  function automatic logic is_bit_state(input logic [2:0] s);
    return (s == S_START) || (s == S_DATA) || (s == S_PARITY) || (s == S_STOP);
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample edge counter and bit counter; both clear while enable_i is low.
module edge_bit_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [5:0] prescale_i,
  output logic [5:0] edge_cnt_o,
  output logic [3:0] bit_cnt_o
);

  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    edge_cnt_d = 6'd0;
    bit_cnt_d  = 4'd0;
    if (enable_i) begin
      if (edge_cnt_q == prescale_i - 6'd1) begin
        edge_cnt_d = 6'd0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
      end else begin
        edge_cnt_d = edge_cnt_q + 6'd1;
        bit_cnt_d  = bit_cnt_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      edge_cnt_q <= 6'd0;
      bit_cnt_q  <= 4'd0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: times start/data/parity/stop bits from the
// oversample counters and pulses the checker and deserializer enables.
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_in_i,
  input  logic       par_en_i,
  input  logic [5:0] prescale_i,
  input  logic       strt_glitch_i,
  input  logic       par_err_i,
  input  logic       stp_err_i,
  output logic       dat_samp_en_o,
  output logic       strt_chk_en_o,
  output logic       par_chk_en_o,
  output logic       stp_chk_en_o,
  output logic       deser_en_o,
  output logic       data_valid_o,
  output logic [5:0] edge_cnt_o,
  output logic [3:0] bit_cnt_o
);

  logic [2:0] state_q, state_d;
  logic [5:0] presc_q, presc_d;
  logic       par_en_q, par_en_d;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       last_edge;
  logic       chk_hit;
  logic       frame_start;
  logic       cnt_en;

  assign last_edge = (edge_cnt == presc_q - 6'd1);
  assign chk_hit   = (edge_cnt == chk_edge(presc_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!rx_in_i) state_d = S_START;
      S_START:   if (last_edge) state_d = strt_glitch_i ? S_IDLE : S_DATA;
      S_DATA:    if (last_edge && bit_cnt == 4'd8) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY:  if (last_edge) state_d = S_STOP;
      S_STOP:    if (last_edge) state_d = S_ERR_CHK;
      S_ERR_CHK: state_d = rx_in_i ? S_IDLE : S_START;
      default:   state_d = S_IDLE;
    endcase
  end

  // Counting only across bit-to-bit transitions makes every bit state start at zero.
  assign cnt_en      = is_bit_state(state_q) && is_bit_state(state_d);
  assign frame_start = (state_q == S_IDLE) && (state_d == S_START);

  always_comb begin
    presc_d  = presc_q;
    par_en_d = par_en_q;
    if (frame_start) begin
      presc_d  = legalize_prescale(prescale_i);
      par_en_d = par_en_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      presc_q  <= PRESCALE_8;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      par_en_q <= par_en_d;
    end
  end

  edge_bit_counter u_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (cnt_en),
    .prescale_i (presc_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt)
  );

  always_comb begin
    dat_samp_en_o = 1'b0;
    strt_chk_en_o = 1'b0;
    par_chk_en_o  = 1'b0;
    stp_chk_en_o  = 1'b0;
    deser_en_o    = 1'b0;
    data_valid_o  = 1'b0;
    case (state_q)
      S_START: begin
        dat_samp_en_o = 1'b1;
        strt_chk_en_o = chk_hit;
      end
      S_DATA: begin
        dat_samp_en_o = 1'b1;
        deser_en_o    = chk_hit;
      end
      S_PARITY: begin
        dat_samp_en_o = 1'b1;
        par_chk_en_o  = chk_hit;
      end
      S_STOP: begin
        dat_samp_en_o = 1'b1;
        stp_chk_en_o  = chk_hit;
      end
      S_ERR_CHK: data_valid_o = !stp_err_i && (!par_err_i || !par_en_q);
      default: ;
    endcase
  end

  assign edge_cnt_o = edge_cnt;
  assign bit_cnt_o  = bit_cnt;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomized and directed frames for uart_rx_fsm, compared cycle by cycle
// against an arithmetic frame-timing model.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxIn;
  logic       parEn;
  logic [5:0] prescale;
  logic       strtGlitch;
  logic       parErr;
  logic       stpErr;
  logic       datSampEn, strtChkEn, parChkEn, stpChkEn, deserEn, dataValid;
  logic [5:0] edgeCnt;
  logic [3:0] bitCnt;

  int checks = 0;
  int failures = 0;
  int mP = 8;
  bit mPar = 1'b0;

  uart_rx_fsm dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rx_in_i       (rxIn),
    .par_en_i      (parEn),
    .prescale_i    (prescale),
    .strt_glitch_i (strtGlitch),
    .par_err_i     (parErr),
    .stp_err_i     (stpErr),
    .dat_samp_en_o (datSampEn),
    .strt_chk_en_o (strtChkEn),
    .par_chk_en_o  (parChkEn),
    .stp_chk_en_o  (stpChkEn),
    .deser_en_o    (deserEn),
    .data_valid_o  (dataValid),
    .edge_cnt_o    (edgeCnt),
    .bit_cnt_o     (bitCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obsVec();
    return {datSampEn, strtChkEn, deserEn, parChkEn, stpChkEn, dataValid, edgeCnt, bitCnt};
  endfunction

  function automatic int legalP(input logic [5:0] v);
    if (v == 6'd8 || v == 6'd16 || v == 6'd32) return int'(v);
    return 8;
  endfunction

  function automatic logic [5:0] randPresc();
    case ($urandom_range(0, 3))
      0:       return 6'd8;
      1:       return 6'd16;
      2:       return 6'd32;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  // Frame = start + 8 data + optional parity + stop, each P cycles long;
  // a start glitch truncates it to the start bit and returns to idle.
  function automatic logic [15:0] modelOut(input int t, input int p, input bit par,
                                           input bit glitch, input bit pe, input bit se);
    int nBits = glitch ? 1 : (par ? 11 : 10);
    int len = nBits * p;
    int bitIdx = 0;
    int edgeIdx = 0;
    logic samp = 1'b0, s = 1'b0, d = 1'b0, pc = 1'b0, sc = 1'b0, dv = 1'b0;
    if (t < len) begin
      bitIdx = t / p;
      edgeIdx = t % p;
      samp = 1'b1;
      if (edgeIdx == p / 2 + 2) begin
        if (bitIdx == 0) s = 1'b1;
        else if (bitIdx <= 8) d = 1'b1;
        else if (par && bitIdx == 9) pc = 1'b1;
        else sc = 1'b1;
      end
    end else if (!glitch) begin
      dv = !se && (!pe || !par);
    end
    return {samp, s, d, pc, sc, dv, edgeIdx[5:0], bitIdx[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // midPresc: -1 none, -2 jitter prescale/parity every cycle, >=0 change once mid-frame.
  task automatic applyStimulus(input string tag, input logic [5:0] presc, input bit par,
                               input bit glitch, input bit pe, input bit se,
                               input logic [7:0] dataByte, input bit fromIdle,
                               input bit nextLow, input bit noise, input int midPresc,
                               input int rstAt);
    int nBits, len, bi;
    int strtSeen = 0, deserSeen = 0, parSeen = 0, stpSeen = 0, dvAt = 0;
    logic [15:0] o;
    logic [10:0] serial;
    bit expDv;
    strtGlitch = glitch;
    parErr = pe;
    stpErr = se;
    if (fromIdle) begin
      rxIn = 1'b1;
      step();
      checkOutput({tag, " idle"}, obsVec(), 16'h0000);
      prescale = presc;
      parEn = par;
      rxIn = 1'b0;
      mP = legalP(presc);
      mPar = par;
    end
    step();
    nBits = glitch ? 1 : (mPar ? 11 : 10);
    len = nBits * mP;
    expDv = !glitch && !se && (!pe || !mPar);
    serial = {2'b11, dataByte, 1'b0};
    if (mPar) serial[9] = ^dataByte;
    for (int t = 0; t <= len; t++) begin
      o = obsVec();
      checkOutput($sformatf("%s t=%0d", tag, t), o, modelOut(t, mP, mPar, glitch, pe, se));
      if (o[14]) strtSeen++;
      if (o[13]) deserSeen++;
      if (o[12]) parSeen++;
      if (o[11]) stpSeen++;
      if (o[10] && dvAt == 0) dvAt = t + 1;
      if (t == rstAt) begin
        #2 rst = 1'b1;
        #1 checkOutput({tag, " asyncReset"}, obsVec(), 16'h0000);
        #2 rst = 1'b0;
        rxIn = 1'b1;
        mP = 8;
        mPar = 1'b0;
        return;
      end
      if (t == len) begin
        rxIn = nextLow ? 1'b0 : 1'b1;
      end else begin
        bi = (t + 1) / mP;
        if (noise) rxIn = 1'($urandom_range(0, 1));
        else rxIn = (bi < nBits) ? serial[4'(bi)] : 1'b1;
        if (midPresc == -2) begin
          prescale = randPresc();
          parEn = 1'($urandom_range(0, 1));
        end else if (midPresc >= 0 && t == len / 2) begin
          prescale = 6'(midPresc);
        end
        step();
      end
    end
    checkOutput({tag, " strtPulses"}, 16'(strtSeen), 16'd1);
    checkOutput({tag, " deserPulses"}, 16'(deserSeen), glitch ? 16'd0 : 16'd8);
    checkOutput({tag, " parPulses"}, 16'(parSeen), (!glitch && mPar) ? 16'd1 : 16'd0);
    checkOutput({tag, " stpPulses"}, 16'(stpSeen), glitch ? 16'd0 : 16'd1);
    checkOutput({tag, " validCycle"}, 16'(dvAt), expDv ? 16'(len + 1) : 16'd0);
  endtask

  initial begin
    bit prevLow;
    bit g, pe, se, nl, par;
    rst = 1'b1;
    rxIn = 1'b1;
    parEn = 1'b0;
    prescale = 6'd8;
    strtGlitch = 1'b0;
    parErr = 1'b0;
    stpErr = 1'b0;
    #3;
    checkOutput("resetState", obsVec(), 16'h0000);
    #10;
    checkOutput("resetHeld", obsVec(), 16'h0000);
    #4 rst = 1'b0;
    rxIn = 1'b0;
    #1 checkOutput("idleAfterRelease", obsVec(), 16'h0000);
    rxIn = 1'b1;

    $display("[TB] directed frames");
    applyStimulus("p8parA5", 6'd8, 1, 0, 0, 0, 8'hA5, 1, 0, 0, -1, -1);
    applyStimulus("p16noPar3C", 6'd16, 0, 0, 0, 0, 8'h3C, 1, 0, 0, -1, -1);
    applyStimulus("p8glitch", 6'd8, 1, 1, 0, 0, 8'h00, 1, 0, 0, -1, -1);
    applyStimulus("p32parErr", 6'd32, 1, 0, 1, 0, 8'h5A, 1, 0, 0, -1, -1);
    applyStimulus("parErrNoPar", 6'd8, 0, 0, 1, 0, 8'h81, 1, 0, 0, -1, -1);
    applyStimulus("stopErr", 6'd16, 1, 0, 0, 1, 8'h7E, 1, 0, 0, -1, -1);
    applyStimulus("illegalP12", 6'd12, 0, 0, 0, 0, 8'hC3, 1, 0, 0, -1, -1);
    applyStimulus("b2bFirst", 6'd8, 1, 0, 0, 0, 8'h11, 1, 1, 0, -1, -1);
    applyStimulus("b2bSecond", 6'd8, 1, 0, 0, 0, 8'h22, 0, 0, 0, -1, -1);
    applyStimulus("midDataReset", 6'd8, 0, 0, 0, 0, 8'hFF, 1, 0, 0, -1, 4 * 8 + 2);
    applyStimulus("p8thenP16", 6'd8, 0, 0, 0, 0, 8'h96, 1, 0, 0, 16, -1);
    applyStimulus("nowP16", 6'd16, 0, 0, 0, 0, 8'h69, 1, 0, 0, -1, -1);

    $display("[TB] randomized frames");
    prevLow = 1'b0;
    for (int i = 0; i < 20; i++) begin
      g = ($urandom_range(0, 5) == 0);
      pe = 1'($urandom_range(0, 1));
      se = ($urandom_range(0, 3) == 0);
      par = 1'($urandom_range(0, 1));
      nl = g ? 1'b0 : 1'($urandom_range(0, 1));
      applyStimulus($sformatf("rand%0d", i), randPresc(), par, g, pe, se,
                    8'($urandom_range(0, 255)), !prevLow, nl,
                    1'($urandom_range(0, 1)), -2, -1);
      prevLow = nl;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
